// File: rtl/core_exec_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module core_exec_div (
    input  logic        clk,
    input  logic        rstn,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        div_kill,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] dq_q;
    logic [31:0] dvs_q;
    logic [31:0] res_q;
    logic        want_rem_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic [32:0] trial;
    logic        qbit;
    logic [31:0] rem_d;
    logic [31:0] dq_d;
    logic [31:0] fin_q;
    logic [31:0] fin_r;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        sgn_ovf;

    always_comb begin
        trial = {rem_q, dq_q[31]} - {1'b0, dvs_q};
        qbit  = ~trial[32];
        // On a negative trial the shifted remainder is below the divisor, so it fits in 32 bits.
        rem_d = qbit ? trial[31:0] : {rem_q[30:0], dq_q[31]};
        dq_d  = {dq_q[30:0], qbit};
        fin_q = neg_q_q ? -dq_d : dq_d;
        fin_r = neg_r_q ? -rem_d : rem_d;

        is_signed = ~div_op[0];
        abs_a     = (is_signed && rs1[31]) ? -rs1 : rs1;
        abs_b     = (is_signed && rs2[31]) ? -rs2 : rs2;
        div_zero  = (rs2 == '0);
        sgn_ovf   = is_signed && (rs1 == 32'h8000_0000) && (rs2 == '1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            dvs_q      <= '0;
            res_q      <= '0;
            want_rem_q <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start && !div_kill) begin
                        want_rem_q <= div_op[1];
                        neg_q_q    <= is_signed && (rs1[31] ^ rs2[31]);
                        neg_r_q    <= is_signed && rs1[31];
                        dq_q       <= abs_a;
                        dvs_q      <= abs_b;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        if (div_zero) begin
                            res_q   <= div_op[1] ? rs1 : '1;
                            state_q <= DONE;
                        end else if (sgn_ovf) begin
                            res_q   <= div_op[1] ? '0 : 32'h8000_0000;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_kill) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dq_q  <= dq_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            res_q   <= want_rem_q ? fin_r : fin_q;
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_busy   = (state_q != IDLE);
    assign div_done   = (state_q == DONE);
    assign div_result = res_q;

endmodule

// File: tb/tb_core_exec_div.sv
// Directed bench for core_exec_div: cycle-level reference model checked every cycle,
// plus literal latency/result expectations for each directed operation.
module tb_core_exec_div;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        div_start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        div_kill = 1'b0;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    int vectors = 0;
    int errs = 0;

    core_exec_div dut (
        .clk        (clk),
        .rstn       (rstn),
        .div_start  (div_start),
        .div_op     (div_op),
        .rs1        (rs1),
        .rs2        (rs2),
        .div_kill   (div_kill),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: cycles of busy remaining (1 = the done cycle) and the visible result.
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    bit          m_en = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_left = 0;
            m_res  = '0;
            m_en   = 1'b1;
        end else if (m_left == 0) begin
            if (div_start && !div_kill) begin
                m_pend = ref_div(div_op, rs1, rs2);
                m_left = is_special(div_op, rs1, rs2) ? 1 : 33;
                if (m_left == 1) m_res = m_pend;
            end
        end else if (div_kill) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 1) m_res = m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("model busy", {31'b0, div_busy}, {31'b0, m_left > 0});
            chk("model done", {31'b0, div_done}, {31'b0, m_left == 1});
            chk("model result", div_result, m_res);
        end
    end

    // Entered just after a rising edge in cycle n0; returns the cycle where done was seen.
    task automatic wait_done(input int n0, input int limit, output int n);
        n = n0;
        while (n <= limit) begin
            @(negedge clk);
            if (div_done) return;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        @(posedge clk);
        #1;
        div_op = op;
        rs1 = a;
        rs2 = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_done(1, 40, n);
        chk({name, " latency"}, n, exp_lat);
        chk({name, " result"}, div_result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'b0, div_busy}, 32'd0);
        chk("reset done", {31'b0, div_done}, 32'd0);
        chk("reset result", div_result, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_op("DIV x/0", 2'b00, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("REMU x/0", 2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 1);
        run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("DIVU maxneg/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
        run_op("REM minint/3", 2'b10, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 33);
        run_op("DIVU 0xFFFFFFF9/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);

        // Kill in cycle 10 of a DIVU 100/7.
        @(posedge clk);
        #1;
        div_op = 2'b01;
        rs1 = 32'd100;
        rs2 = 32'd7;
        div_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            div_start = 1'b0;
        end
        div_kill = 1'b1;
        @(posedge clk);
        #1;
        div_kill = 1'b0;
        @(negedge clk);
        chk("kill busy", {31'b0, div_busy}, 32'd0);
        chk("kill result", div_result, 32'h7FFF_FFFC);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        chk("kill no done", dones, 32'd0);

        // Start together with kill in IDLE is dropped.
        @(posedge clk);
        #1;
        div_op = 2'b01;
        rs1 = 32'd9;
        rs2 = 32'd3;
        div_start = 1'b1;
        div_kill = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        div_kill = 1'b0;
        @(negedge clk);
        chk("start+kill busy", {31'b0, div_busy}, 32'd0);

        // Start held high through CALC/DONE; operands change while busy.
        @(posedge clk);
        #1;
        div_op = 2'b01;
        rs1 = 32'd100;
        rs2 = 32'd7;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        rs1 = 32'd50;
        rs2 = 32'd5;
        wait_done(1, 40, n);
        chk("held first latency", n, 32'd33);
        chk("held first result", div_result, 32'd14);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_done(35, 80, n);
        chk("held second latency", n, 32'd67);
        chk("held second result", div_result, 32'd10);

        // Reset mid-CALC.
        @(posedge clk);
        #1;
        div_op = 2'b01;
        rs1 = 32'd100;
        rs2 = 32'd7;
        div_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            div_start = 1'b0;
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("midreset busy", {31'b0, div_busy}, 32'd0);
        chk("midreset done", {31'b0, div_done}, 32'd0);
        chk("midreset result", div_result, 32'd0);
        run_op("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
